// File: rtl/data_path_pkg.sv
// Shared constants for the Mini-SRC single-bus datapath: default word width
// and the ALU operation encoding with its priority resolver.
package data_path_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned OP_W          = 3;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t op_none = 3'd0;
  localparam alu_op_t op_inc  = 3'd1;
  localparam alu_op_t op_and  = 3'd2;
  localparam alu_op_t op_or   = 3'd3;
  localparam alu_op_t op_add  = 3'd4;
  localparam alu_op_t op_sub  = 3'd5;

  // Collapse the one-hot-ish op strobes into a single op, IncPC highest.
  function automatic alu_op_t alu_op_select(
    input logic inc_s,
    input logic and_s,
    input logic or_s,
    input logic add_s,
    input logic sub_s
  );
    alu_op_t op;
    op = op_none;
    if (inc_s)      op = op_inc;
    else if (and_s) op = op_and;
    else if (or_s)  op = op_or;
    else if (add_s) op = op_add;
    else if (sub_s) op = op_sub;
    return op;
  endfunction

endpackage

// File: rtl/data_path_register32.sv
// Generic load-enabled register with synchronous active-high clear.
module register32 #(
  parameter int unsigned       WIDTH     = data_path_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge Clock) begin
    if (Clear)       q <= RESET_VAL;
    else if (enable) q <= d;
  end

endmodule

// File: rtl/data_path.sv
// Mini-SRC single-bus datapath: R3/R4/R7, PC, IR, MAR, MDR, Y, Zhi/Zlo and
// a 32-bit ALU sharing one bus driven by priority-selected out strobes.
module data_path
  import data_path_pkg::*;
#(
  parameter int unsigned      WIDTH    = data_path_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             PCout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             R3out,
  input  logic             R7out,
  input  logic             MARin,
  input  logic             Zin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R7in,
  input  logic             IncPC,
  input  logic             Read,
  input  logic             AND,
  input  logic             OR,
  input  logic             ADD,
  input  logic             SUB,
  input  logic [WIDTH-1:0] Mdatain
);

  logic [WIDTH-1:0]   BusMuxOut;
  logic [WIDTH-1:0]   BusMuxInR3;
  logic [WIDTH-1:0]   BusMuxInR4;
  logic [WIDTH-1:0]   BusMuxInR7;
  logic [WIDTH-1:0]   BusMuxInPC;
  logic [WIDTH-1:0]   BusMuxInIR;
  logic [WIDTH-1:0]   BusMuxInMDR;
  logic [WIDTH-1:0]   BusMuxInZlo;
  logic [WIDTH-1:0]   BusMuxInZhi;
  logic [WIDTH-1:0]   Y_Out;
  logic [WIDTH-1:0]   mar_q;
  logic [WIDTH-1:0]   mdr_d;
  logic [WIDTH-1:0]   alu_result;
  logic [2*WIDTH-1:0] alu_c;
  alu_op_t            alu_op;

  // Bus source priority: MDR > PC > Zlo > R3 > R7, idle bus reads 0.
  always_comb begin
    BusMuxOut = '0;
    if (MDRout)       BusMuxOut = BusMuxInMDR;
    else if (PCout)   BusMuxOut = BusMuxInPC;
    else if (Zlowout) BusMuxOut = BusMuxInZlo;
    else if (R3out)   BusMuxOut = BusMuxInR3;
    else if (R7out)   BusMuxOut = BusMuxInR7;
  end

  assign mdr_d = Read ? Mdatain : BusMuxOut;

  // ALU: A = Y, B = bus; all arithmetic wraps at the word width.
  always_comb begin
    alu_op     = alu_op_select(IncPC, AND, OR, ADD, SUB);
    alu_result = '0;
    case (alu_op)
      op_inc:  alu_result = BusMuxOut + WIDTH'(1);
      op_and:  alu_result = Y_Out & BusMuxOut;
      op_or:   alu_result = Y_Out | BusMuxOut;
      op_add:  alu_result = Y_Out + BusMuxOut;
      op_sub:  alu_result = Y_Out - BusMuxOut;
      default: alu_result = '0;
    endcase
  end

  assign alu_c = {WIDTH'(0), alu_result};

  register32 #(.WIDTH(WIDTH)) R3 (
    .Clock(Clock), .Clear(Clear), .enable(R3in), .d(BusMuxOut), .q(BusMuxInR3)
  );

  register32 #(.WIDTH(WIDTH)) R4 (
    .Clock(Clock), .Clear(Clear), .enable(R4in), .d(BusMuxOut), .q(BusMuxInR4)
  );

  register32 #(.WIDTH(WIDTH)) R7 (
    .Clock(Clock), .Clear(Clear), .enable(R7in), .d(BusMuxOut), .q(BusMuxInR7)
  );

  register32 #(.WIDTH(WIDTH), .RESET_VAL(PC_RESET)) PC (
    .Clock(Clock), .Clear(Clear), .enable(PCin), .d(BusMuxOut), .q(BusMuxInPC)
  );

  register32 #(.WIDTH(WIDTH)) IR (
    .Clock(Clock), .Clear(Clear), .enable(IRin), .d(BusMuxOut), .q(BusMuxInIR)
  );

  register32 #(.WIDTH(WIDTH)) MAR (
    .Clock(Clock), .Clear(Clear), .enable(MARin), .d(BusMuxOut), .q(mar_q)
  );

  register32 #(.WIDTH(WIDTH)) MDR (
    .Clock(Clock), .Clear(Clear), .enable(MDRin), .d(mdr_d), .q(BusMuxInMDR)
  );

  register32 #(.WIDTH(WIDTH)) Y (
    .Clock(Clock), .Clear(Clear), .enable(Yin), .d(BusMuxOut), .q(Y_Out)
  );

  register32 #(.WIDTH(WIDTH)) ZHI (
    .Clock(Clock), .Clear(Clear), .enable(Zin), .d(alu_c[2*WIDTH-1:WIDTH]), .q(BusMuxInZhi)
  );

  register32 #(.WIDTH(WIDTH)) ZLO (
    .Clock(Clock), .Clear(Clear), .enable(Zin), .d(alu_c[WIDTH-1:0]), .q(BusMuxInZlo)
  );

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path; observes internal nets
// hierarchically since the datapath exposes no output ports.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, Zlowout, MDRout, R3out, R7out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, R3in, R4in, R7in;
  logic        IncPC, Read, AND, OR, ADD, SUB;
  logic [31:0] Mdatain;

  int n_tests = 0;
  int n_fail  = 0;

  data_path dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R3out(R3out), .R7out(R7out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .R3in(R3in), .R4in(R4in), .R7in(R7in),
    .IncPC(IncPC), .Read(Read), .AND(AND), .OR(OR), .ADD(ADD), .SUB(SUB),
    .Mdatain(Mdatain)
  );

  always #5 Clock = ~Clock;

  task automatic idle();
    Clear = 0;
    PCout = 0; Zlowout = 0; MDRout = 0; R3out = 0; R7out = 0;
    MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
    R3in = 0; R4in = 0; R7in = 0;
    IncPC = 0; Read = 0; AND = 0; OR = 0; ADD = 0; SUB = 0;
  endtask

  // Apply the currently driven controls for one edge, then release them.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    Mdatain = 32'h0;
    Clear = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR3 !== 32'h0 || dut.BusMuxInR4 !== 32'h0 || dut.BusMuxInR7 !== 32'h0) begin
      $display("FAIL reset_gpr R3=%h R4=%h R7=%h expected 0", dut.BusMuxInR3, dut.BusMuxInR4, dut.BusMuxInR7);
      n_fail++;
    end
    n_tests++;
    if (dut.BusMuxInPC !== 32'h0 || dut.BusMuxInIR !== 32'h0 || dut.MAR.q !== 32'h0 ||
        dut.BusMuxInMDR !== 32'h0 || dut.Y_Out !== 32'h0 || dut.BusMuxInZlo !== 32'h0 ||
        dut.BusMuxInZhi !== 32'h0) begin
      $display("FAIL reset_special PC=%h IR=%h MAR=%h MDR=%h Y=%h Zlo=%h Zhi=%h expected 0",
               dut.BusMuxInPC, dut.BusMuxInIR, dut.MAR.q, dut.BusMuxInMDR, dut.Y_Out,
               dut.BusMuxInZlo, dut.BusMuxInZhi);
      n_fail++;
    end
    n_tests++;
    if (dut.BusMuxOut !== 32'h0) begin
      $display("FAIL reset_bus got=%h expected=0", dut.BusMuxOut);
      n_fail++;
    end
  endtask

  task automatic test_register_loads();
    logic [31:0] vals [3];
    logic [31:0] got;
    vals[0] = 32'h22; vals[1] = 32'h24; vals[2] = 32'h28;
    for (int i = 0; i < 3; i++) begin
      Mdatain = vals[i]; Read = 1; MDRin = 1;
      tick();
      MDRout = 1;
      if (i == 0) R3in = 1; else if (i == 1) R7in = 1; else R4in = 1;
      #1;
      n_tests++;
      if (dut.BusMuxOut !== vals[i]) begin
        $display("FAIL load_bus[%0d] got=%h expected=%h", i, dut.BusMuxOut, vals[i]);
        n_fail++;
      end
      tick();
      got = (i == 0) ? dut.BusMuxInR3 : (i == 1) ? dut.BusMuxInR7 : dut.BusMuxInR4;
      n_tests++;
      if (got !== vals[i]) begin
        $display("FAIL load_reg[%0d] got=%h expected=%h", i, got, vals[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_fetch();
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    tick();
    n_tests++;
    if (dut.MAR.q !== 32'h0 || dut.BusMuxInZlo !== 32'h1) begin
      $display("FAIL fetch_t0 MAR=%h Zlo=%h expected MAR=0 Zlo=1", dut.MAR.q, dut.BusMuxInZlo);
      n_fail++;
    end
    Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h2A2B8000;
    tick();
    n_tests++;
    if (dut.BusMuxInPC !== 32'h1 || dut.BusMuxInMDR !== 32'h2A2B8000) begin
      $display("FAIL fetch_t1 PC=%h MDR=%h expected PC=1 MDR=2a2b8000", dut.BusMuxInPC, dut.BusMuxInMDR);
      n_fail++;
    end
    MDRout = 1; IRin = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInIR !== 32'h2A2B8000) begin
      $display("FAIL fetch_t2 IR=%h expected=2a2b8000", dut.BusMuxInIR);
      n_fail++;
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp [4];
    exp[0] = 32'h00000020; exp[1] = 32'h00000026;
    exp[2] = 32'h00000046; exp[3] = 32'hFFFFFFFE;
    for (int i = 0; i < 4; i++) begin
      R3out = 1; Yin = 1;
      tick();
      R7out = 1; Zin = 1;
      AND = (i == 0); OR = (i == 1); ADD = (i == 2); SUB = (i == 3);
      tick();
      Zlowout = 1; R4in = 1;
      tick();
      n_tests++;
      if (dut.BusMuxInR4 !== exp[i] || dut.BusMuxInZhi !== 32'h0) begin
        $display("FAIL alu_op[%0d] R4=%h Zhi=%h expected R4=%h Zhi=0",
                 i, dut.BusMuxInR4, dut.BusMuxInZhi, exp[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_no_source();
    R4in = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR4 !== 32'h0) begin
      $display("FAIL idle_bus_load R4=%h expected=0", dut.BusMuxInR4);
      n_fail++;
    end
    R3out = 1; Zin = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInZlo !== 32'h0) begin
      $display("FAIL no_op_z Zlo=%h expected=0", dut.BusMuxInZlo);
      n_fail++;
    end
  endtask

  task automatic test_clear();
    Clear = 1; R3in = 1; MDRout = 1; PCin = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR3 !== 32'h0 || dut.BusMuxInPC !== 32'h0 || dut.BusMuxInMDR !== 32'h0 ||
        dut.BusMuxInIR !== 32'h0 || dut.BusMuxInR7 !== 32'h0 || dut.Y_Out !== 32'h0) begin
      $display("FAIL clear_mid R3=%h PC=%h MDR=%h IR=%h R7=%h Y=%h expected 0",
               dut.BusMuxInR3, dut.BusMuxInPC, dut.BusMuxInMDR, dut.BusMuxInIR,
               dut.BusMuxInR7, dut.Y_Out);
      n_fail++;
    end
    Mdatain = 32'h55; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; R3in = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR3 !== 32'h55) begin
      $display("FAIL clear_resume R3=%h expected=55", dut.BusMuxInR3);
      n_fail++;
    end
  endtask

  task automatic test_priority();
    // PC <- 1 so PC and MDR hold distinct values.
    PCout = 1; IncPC = 1; Zin = 1;
    tick();
    Zlowout = 1; PCin = 1;
    tick();
    MDRout = 1; PCout = 1; R3in = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR3 !== 32'h55) begin
      $display("FAIL prio_mdr_pc R3=%h expected=55", dut.BusMuxInR3);
      n_fail++;
    end
    PCout = 1; Zlowout = 1; R3out = 1; R4in = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR4 !== 32'h1) begin
      $display("FAIL prio_pc_zlo R4=%h expected=1", dut.BusMuxInR4);
      n_fail++;
    end
    Mdatain = 32'h0F; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; R7in = 1;
    tick();
    R3out = 1; Yin = 1;
    tick();
    R7out = 1; AND = 1; ADD = 1; Zin = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInZlo !== 32'h05) begin
      $display("FAIL prio_and_add Zlo=%h expected=05", dut.BusMuxInZlo);
      n_fail++;
    end
    R7out = 1; IncPC = 1; AND = 1; Zin = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInZlo !== 32'h10) begin
      $display("FAIL prio_inc_and Zlo=%h expected=10", dut.BusMuxInZlo);
      n_fail++;
    end
    R3out = 1; R3in = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR3 !== 32'h55) begin
      $display("FAIL self_load R3=%h expected=55", dut.BusMuxInR3);
      n_fail++;
    end
    R3out = 1; R7out = 1; R4in = 1;
    tick();
    n_tests++;
    if (dut.BusMuxInR4 !== 32'h55) begin
      $display("FAIL prio_r3_r7 R4=%h expected=55", dut.BusMuxInR4);
      n_fail++;
    end
  endtask

  initial begin
    idle();
    Mdatain = 32'h0;
    @(negedge Clock);
    test_reset();
    test_register_loads();
    test_fetch();
    test_alu_ops();
    test_no_source();
    test_clear();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
